// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding and the ASCII hex conversion used on the display path.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'h0, nib};
        end
        return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// Operand/command and result bundle between a requester and the addsub_seq engine.
// The requester (master) drives start/op/operands; the engine (slave) returns status and result.
interface addsub_if #(
    parameter int WIDTH = 8
);
    logic             Gl_adder_start;
    logic             Gl_subtract;
    logic [WIDTH-1:0] Gl_r1;
    logic [WIDTH-1:0] Gl_r2;
    logic             L_busy;
    logic             L_adder_rdy;
    logic [WIDTH-1:0] L_result;
    logic             L_carry;
    logic             L_ovf;
    logic             L_zero;
    logic             L_neg;
    logic [7:0]       L_adder_data;

    modport master (
        output Gl_adder_start, Gl_subtract, Gl_r1, Gl_r2,
        input  L_busy, L_adder_rdy, L_result, L_carry, L_ovf, L_zero, L_neg, L_adder_data
    );

    modport slave (
        input  Gl_adder_start, Gl_subtract, Gl_r1, Gl_r2,
        output L_busy, L_adder_rdy, L_result, L_carry, L_ovf, L_zero, L_neg, L_adder_data
    );
endinterface

// File: rtl/addsub_digit.sv
// DIGIT-wide combinational ripple-carry slice built from per-bit full-adder equations.
module addsub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic chain;

    always_comb begin
        s     = '0;
        chain = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]  = a[i] ^ b[i] ^ chain;
            chain = (a[i] & b[i]) | (chain & (a[i] ^ b[i]));
        end
        cout = chain;
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: latches operands on start, resolves DIGIT bits per clock,
// then pulses ready with the full result, status flags and an ASCII hex of the low nibble.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic    clk,
    input  logic    Gl_rst,
    addsub_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             rdy_q, rdy_d;
    logic             cflag_q, cflag_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic [7:0]       data_q, data_d;

    logic [31:0]      base;
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout;

    // Only one slice exists; the digit counter steers it across the latched operands.
    assign base  = 32'(count_q) * 32'(DIGIT);
    assign dig_a = a_q[base +: DIGIT];
    assign dig_b = b_q[base +: DIGIT];

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
        cflag_d = cflag_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.Gl_adder_start) begin
                    // Subtract as A + ~B + 1: invert B here and seed the carry with 1.
                    a_d     = bus.Gl_r1;
                    b_d     = bus.Gl_r2 ^ {WIDTH{bus.Gl_subtract}};
                    carry_d = bus.Gl_subtract;
                    count_d = '0;
                    state_d = CALC;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                res_d[base +: DIGIT] = dig_s;
                carry_d              = dig_cout;
                if (count_q == LAST) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    cflag_d = dig_cout;
                    neg_d   = res_d[WIDTH-1];
                    zero_d  = (res_d == '0);
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                    data_d  = hex_to_ascii(res_d[3:0]);
                end else begin
                    count_d = count_q + CNT_W'(1);
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge Gl_rst) begin
        if (Gl_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
            cflag_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            data_q  <= ASCII_0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
            cflag_q <= cflag_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
        end
    end

    assign bus.L_busy       = busy_q;
    assign bus.L_adder_rdy  = rdy_q;
    assign bus.L_result     = res_q;
    assign bus.L_carry      = cflag_q;
    assign bus.L_ovf        = ovf_q;
    assign bus.L_zero       = zero_q;
    assign bus.L_neg        = neg_q;
    assign bus.L_adder_data = data_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: randomized and directed operations on an 8-bit/2-bit engine,
// plus directed checks on 8-bit/8-bit and 16-bit/1-bit configurations.
module tb_addsub_seq;

    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    typedef struct {
        logic [31:0] res;
        bit          c;
        bit          v;
        bit          z;
        bit          n;
        logic [7:0]  asc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_t0 = -1000;
    bit   in_rst = 1'b1;
    bit   mon_busy;
    bit   mon_rdy;
    exp_t q[$];
    exp_t last;
    exp_t ex;
    int   t_issue;
    int   k;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub_if #(.WIDTH(8))  m_if ();
    addsub_if #(.WIDTH(8))  b_if ();
    addsub_if #(.WIDTH(16)) w_if ();

    addsub_seq #(.WIDTH(8),  .DIGIT(2)) dut     (.clk(clk), .Gl_rst(rst), .bus(m_if));
    addsub_seq #(.WIDTH(8),  .DIGIT(8)) dut_n1  (.clk(clk), .Gl_rst(rst), .bus(b_if));
    addsub_seq #(.WIDTH(16), .DIGIT(1)) dut_n16 (.clk(clk), .Gl_rst(rst), .bus(w_if));

    // Reference: true integer arithmetic and range checks, reduced modulo 2^w.
    function automatic exp_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b, input bit s);
        exp_t   e;
        longint ua, ub, md, sa, sb, sr, raw;
        int     nib;
        md    = longint'(1) << w;
        ua    = longint'(a);
        ub    = longint'(b);
        sa    = (ua >= md / 2) ? ua - md : ua;
        sb    = (ub >= md / 2) ? ub - md : ub;
        sr    = s ? sa - sb : sa + sb;
        raw   = s ? ua - ub : ua + ub;
        raw   = ((raw % md) + md) % md;
        e.res = 32'(raw);
        e.c   = s ? (ua >= ub) : (ua + ub >= md);
        e.v   = (sr < -(md / 2)) || (sr >= md / 2);
        e.z   = (raw == 0);
        e.n   = (raw >= md / 2);
        nib   = int'(raw % 16);
        e.asc = (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
        e.cyc = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Drive one cycle of stimulus; an accepted start pushes its expected response.
    task automatic step(input bit st, input logic [7:0] a, input logic [7:0] b, input bit s);
        exp_t e;
        @(negedge clk);
        m_if.Gl_adder_start = st;
        m_if.Gl_r1          = a;
        m_if.Gl_r2          = b;
        m_if.Gl_subtract    = s;
        if (st && (cyc + 1 >= last_t0 + N + 2)) begin
            last_t0 = cyc + 1;
            e       = ref_op(W, 32'(a), 32'(b), s);
            e.cyc   = cyc + 1 + N;
            q.push_back(e);
        end
    endtask

    task automatic idle_step();
        step(1'b0, pick(), pick(), 1'($urandom_range(0, 1)));
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input bit s);
        step(1'b1, a, b, s);
        repeat (N + 2) idle_step();
    endtask

    task automatic set_reset_expect();
        last.res = '0; last.c = 0; last.v = 0; last.z = 0; last.n = 0;
        last.asc = 8'h30; last.cyc = 0;
        q.delete();
        last_t0 = -1000;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   m_if.L_busy, 0);
        chk({tag, "_rdy"},    m_if.L_adder_rdy, 0);
        chk({tag, "_result"}, m_if.L_result, 0);
        chk({tag, "_carry"},  m_if.L_carry, 0);
        chk({tag, "_ovf"},    m_if.L_ovf, 0);
        chk({tag, "_zero"},   m_if.L_zero, 0);
        chk({tag, "_neg"},    m_if.L_neg, 0);
        chk({tag, "_data"},   m_if.L_adder_data, 32'h30);
    endtask

    // Monitor: ready timing, busy window, result/flags on ready and hold afterwards.
    always @(negedge clk) begin
        if (!in_rst) begin
            mon_busy = (cyc >= last_t0) && (cyc <= last_t0 + N - 1);
            mon_rdy  = (q.size() > 0) && (q[0].cyc == cyc);
            chk("busy", m_if.L_busy, mon_busy);
            chk("rdy", m_if.L_adder_rdy, mon_rdy);
            if (mon_rdy) begin
                last = q.pop_front();
                chk("result", m_if.L_result, last.res);
            end else if (!mon_busy) begin
                chk("result_hold", m_if.L_result, last.res);
            end
            chk("carry", m_if.L_carry, last.c);
            chk("ovf",   m_if.L_ovf,   last.v);
            chk("zero",  m_if.L_zero,  last.z);
            chk("neg",   m_if.L_neg,   last.n);
            chk("data",  m_if.L_adder_data, last.asc);
        end
    end

    initial begin
        rst = 1'b1;
        m_if.Gl_adder_start = 0; m_if.Gl_subtract = 0; m_if.Gl_r1 = '0; m_if.Gl_r2 = '0;
        b_if.Gl_adder_start = 0; b_if.Gl_subtract = 0; b_if.Gl_r1 = '0; b_if.Gl_r2 = '0;
        w_if.Gl_adder_start = 0; w_if.Gl_subtract = 0; w_if.Gl_r1 = '0; w_if.Gl_r2 = '0;
        set_reset_expect();
        repeat (2) @(negedge clk);
        chk_reset_outputs("init");
        chk("init_n16_data", w_if.L_adder_data, 32'h30);
        #1 rst = 1'b0;
        in_rst = 1'b0;

        // Directed cases on the 8-bit, 2-bit-digit engine.
        op(8'h05, 8'h03, 1'b0);
        op(8'h05, 8'h07, 1'b1);
        op(8'h7F, 8'h01, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
        op(8'h80, 8'h01, 1'b1);
        op(8'h00, 8'h00, 1'b1);

        // A second start while busy must be ignored.
        step(1'b1, 8'h10, 8'h20, 1'b0);
        idle_step();
        step(1'b1, 8'hAA, 8'h20, 1'b0);
        repeat (N + 2) idle_step();

        // Asynchronous reset in the middle of a calculation.
        step(1'b1, 8'h33, 8'h44, 1'b0);
        @(posedge clk);
        #2;
        m_if.Gl_adder_start = 1'b0;
        in_rst = 1'b1;
        rst    = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        set_reset_expect();
        @(negedge clk);
        #1 rst = 1'b0;
        in_rst = 1'b0;
        op(8'h12, 8'h34, 1'b0);

        // Start held high re-triggers back to back.
        repeat (3 * (N + 2)) step(1'b1, pick(), pick(), 1'($urandom_range(0, 1)));

        // Random mix with operands changing every cycle.
        repeat (400) step($urandom_range(0, 2) == 0, pick(), pick(), 1'($urandom_range(0, 1)));
        repeat (N + 3) idle_step();
        chk("queue_drained", q.size(), 0);

        // N = 1 configuration: 0x80 - 0x01.
        @(negedge clk);
        b_if.Gl_adder_start = 1; b_if.Gl_r1 = 8'h80; b_if.Gl_r2 = 8'h01; b_if.Gl_subtract = 1;
        t_issue = cyc;
        ex = ref_op(8, 32'h80, 32'h01, 1'b1);
        @(negedge clk);
        b_if.Gl_adder_start = 0; b_if.Gl_r1 = 8'h5A;
        k = 0;
        while (!b_if.L_adder_rdy && k < 40) begin @(negedge clk); k++; end
        chk("n1_rdy", b_if.L_adder_rdy, 1);
        chk("n1_latency", cyc, t_issue + 2);
        chk("n1_result", b_if.L_result, ex.res);
        chk("n1_ovf", b_if.L_ovf, ex.v);
        chk("n1_carry", b_if.L_carry, ex.c);
        chk("n1_data", b_if.L_adder_data, ex.asc);
        @(negedge clk);
        chk("n1_rdy_drop", b_if.L_adder_rdy, 0);

        // N = 16 configuration: 0x1234 + 0x0FFF.
        @(negedge clk);
        w_if.Gl_adder_start = 1; w_if.Gl_r1 = 16'h1234; w_if.Gl_r2 = 16'h0FFF; w_if.Gl_subtract = 0;
        t_issue = cyc;
        ex = ref_op(16, 32'h1234, 32'h0FFF, 1'b0);
        @(negedge clk);
        w_if.Gl_adder_start = 0; w_if.Gl_r1 = 16'hFFFF;
        chk("n16_busy", w_if.L_busy, 1);
        k = 0;
        while (!w_if.L_adder_rdy && k < 60) begin @(negedge clk); k++; end
        chk("n16_rdy", w_if.L_adder_rdy, 1);
        chk("n16_latency", cyc, t_issue + 17);
        chk("n16_result", w_if.L_result, ex.res);
        chk("n16_carry", w_if.L_carry, ex.c);
        chk("n16_ovf", w_if.L_ovf, ex.v);
        chk("n16_zero", w_if.L_zero, ex.z);
        chk("n16_data", w_if.L_adder_data, ex.asc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
